// File: rtl/interp_sched.sv
// Sample scheduler for the 2x/2x/CIC interpolation chain: frames input audio, drives the
// zero-stuffed or held half-band inputs and phase-locked enable strobes from one frame counter.
module interp_sched #(
  parameter int DATA_W  = 16,
  parameter int FRAME   = 640,
  parameter int LEAD1   = 19,
  parameter int LEAD2   = 9,
  parameter int CIC_DIV = 20,
  parameter int CIC_PH  = 5,
  parameter int UCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              hold_mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] in2,
  output logic              enb_hbf1,
  output logic              enb_hbf2,
  output logic              enb_cic,
  output logic              underrun,
  output logic [UCNT_W-1:0] urun_cnt
);

  localparam int Q  = FRAME / 4;
  localparam int CW = $clog2(FRAME);
  localparam int KW = (CIC_DIV > 1) ? $clog2(CIC_DIV) : 1;

  logic [CW-1:0]     cnt;
  logic [KW-1:0]     cic_cnt;
  logic [DATA_W-1:0] buf_data;
  logic              buf_valid;

  logic ev_load, ev_ins, ev_in2_data, hbf1_hit, hbf2_hit, cic_hit, take, bypass, starve;

  assign s_ready = !buf_valid;

  always_comb begin
    ev_load     = (cnt == CW'(2*Q-1));
    ev_ins      = (cnt == CW'(4*Q-1));
    ev_in2_data = (cnt == CW'(Q-1)) || (cnt == CW'(3*Q-1));
    hbf1_hit    = (cnt == CW'(2*Q-1-LEAD1)) || (cnt == CW'(4*Q-1-LEAD1));
    hbf2_hit    = (cnt == CW'(Q-1-LEAD2))   || (cnt == CW'(2*Q-1-LEAD2)) ||
                  (cnt == CW'(3*Q-1-LEAD2)) || (cnt == CW'(4*Q-1-LEAD2));
    cic_hit     = (cic_cnt == KW'(CIC_PH));
    take        = s_valid && !buf_valid;
    // A sample arriving exactly at the load slot with an empty buffer goes straight to in1.
    bypass      = en && ev_load && !buf_valid && s_valid;
    starve      = ev_load && !buf_valid && !s_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cic_cnt   <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
      in1       <= '0;
      in2       <= '0;
      enb_hbf1  <= 1'b0;
      enb_hbf2  <= 1'b0;
      enb_cic   <= 1'b0;
      underrun  <= 1'b0;
      urun_cnt  <= '0;
    end else begin
      if (en && ev_load && buf_valid) begin
        buf_valid <= 1'b0;
      end else if (take && !bypass) begin
        buf_data  <= s_data;
        buf_valid <= 1'b1;
      end

      if (!en) begin
        cnt      <= '0;
        cic_cnt  <= '0;
        in1      <= '0;
        in2      <= '0;
        enb_hbf1 <= 1'b0;
        enb_hbf2 <= 1'b0;
        enb_cic  <= 1'b0;
        underrun <= 1'b0;
      end else begin
        cnt      <= (cnt == CW'(FRAME-1)) ? '0 : cnt + CW'(1);
        cic_cnt  <= (cic_cnt == KW'(CIC_DIV-1)) ? '0 : cic_cnt + KW'(1);
        enb_hbf1 <= hbf1_hit;
        enb_hbf2 <= hbf2_hit;
        enb_cic  <= cic_hit;
        underrun <= starve;
        if (starve && (urun_cnt != '1))
          urun_cnt <= urun_cnt + UCNT_W'(1);

        if (ev_load) begin
          if (buf_valid)       in1 <= buf_data;
          else if (s_valid)    in1 <= s_data;
          else if (!hold_mode) in1 <= '0;
        end else if (ev_ins && !hold_mode) begin
          in1 <= '0;
        end

        if (ev_in2_data)                        in2 <= out1;
        else if ((ev_load || ev_ins) && !hold_mode) in2 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interp_sched.sv
// Directed bench for interp_sched: strobe phasing, zero-stuff/hold data paths, bypass,
// underrun saturation, run/stop and mid-frame reset.
module tb_interp_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        hold_mode = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] in1, in2;
  logic [15:0] out1 = '0;
  logic        enb_hbf1, enb_hbf2, enb_cic, underrun;
  logic [2:0]  urun_cnt;

  int checks = 0;
  int errors = 0;
  int c = 0;

  interp_sched #(.DATA_W(16), .FRAME(640), .LEAD1(19), .LEAD2(9),
                 .CIC_DIV(20), .CIC_PH(5), .UCNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold_mode(hold_mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .in1(in1), .out1(out1), .in2(in2),
    .enb_hbf1(enb_hbf1), .enb_hbf2(enb_hbf2), .enb_cic(enb_cic),
    .underrun(underrun), .urun_cnt(urun_cnt)
  );

  always #5 clk = ~clk;

  // Reference frame position: value the DUT counter holds during the current cycle.
  always @(posedge clk) begin
    if (!rst_n || !en) c <= 0;
    else               c <= (c == 639) ? 0 : c + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (c=%0d)", tag, got, exp, c);
    end
  endtask

  // Advance to the cycle right after the counter held value v.
  task automatic wait_after(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (c != (v + 1) % 640 && n < 1400);
    if (n >= 1400) check("timeout", 32'(c), 32'((v + 1) % 640));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; hold_mode = 1'b0; s_data = '0; out1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] e_in1, e_in2;
    int p, cnt_ur;
    logic nz;

    // Reset state
    do_reset();
    check("rst_in1", 32'(in1), 0);
    check("rst_in2", 32'(in2), 0);
    check("rst_strobes", {enb_hbf1, enb_hbf2, enb_cic, underrun}, 0);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_urun", 32'(urun_cnt), 0);

    // Full frame with continuous input: strobe phasing and data paths
    s_valid = 1'b1; s_data = 16'h1234; out1 = 16'hFFFB;
    @(negedge clk);
    en = 1'b1;
    e_in1 = '0; e_in2 = '0;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      p = (c + 639) % 640;
      if (p == 319) e_in1 = 16'h1234;
      if (p == 639) e_in1 = 16'h0000;
      if (p == 159 || p == 479) e_in2 = 16'hFFFB;
      if (p == 319 || p == 639) e_in2 = 16'h0000;
      check("hbf1", 32'(enb_hbf1), 32'(p == 300 || p == 620));
      check("hbf2", 32'(enb_hbf2), 32'(p == 150 || p == 310 || p == 470 || p == 630));
      check("cic", 32'(enb_cic), 32'(p % 20 == 5));
      check("in1", 32'(in1), 32'(e_in1));
      check("in2", 32'(in2), 32'(e_in2));
      check("no_urun", 32'(underrun), 0);
    end

    // Starved input, zero insertion: one underrun per frame
    do_reset();
    en = 1'b1;
    cnt_ur = 0; nz = 1'b0;
    for (int i = 0; i < 1280; i++) begin
      @(negedge clk);
      if (underrun) cnt_ur++;
      if (in1 != 0) nz = 1'b1;
    end
    check("urun_pulses", 32'(cnt_ur), 2);
    check("urun_cnt2", 32'(urun_cnt), 2);
    check("in1_stays0", 32'(nz), 0);

    // Hold mode: 0x7FFF persists through insert and underrun
    do_reset();
    hold_mode = 1'b1; s_valid = 1'b1; s_data = 16'h7FFF;
    @(negedge clk);
    s_valid = 1'b0;
    check("hold_buf_full", 32'(s_ready), 0);
    en = 1'b1;
    wait_after(319);
    check("hold_load", 32'(in1), 16'h7FFF);
    check("hold_load_ur", 32'(underrun), 0);
    wait_after(639);
    check("hold_ins", 32'(in1), 16'h7FFF);
    wait_after(319);
    check("hold_ur", 32'(underrun), 1);
    check("hold_ur_in1", 32'(in1), 16'h7FFF);
    check("hold_ur_cnt", 32'(urun_cnt), 1);

    // Bypass load at the load slot with empty buffer
    do_reset();
    en = 1'b1;
    wait_after(318);
    s_valid = 1'b1; s_data = 16'h5A5A;
    @(negedge clk);
    check("byp_in1", 32'(in1), 16'h5A5A);
    check("byp_ur", 32'(underrun), 0);
    check("byp_ready", 32'(s_ready), 1);
    check("byp_cnt", 32'(urun_cnt), 0);
    s_valid = 1'b0;
    wait_after(319);
    check("byp_empty_ur", 32'(underrun), 1);

    // Run/stop mid-frame with a full buffer
    do_reset();
    out1 = 16'hFFFB; s_valid = 1'b1; s_data = 16'hABCD;
    @(negedge clk);
    s_valid = 1'b0;
    en = 1'b1;
    wait_after(199);
    check("stop_pre_in2", 32'(in2), 16'hFFFB);
    check("stop_pre_ready", 32'(s_ready), 0);
    en = 1'b0;
    nz = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({enb_hbf1, enb_hbf2, enb_cic, underrun} != 0 || in1 != 0 || in2 != 0) nz = 1'b1;
    end
    check("stop_quiet", 32'(nz), 0);
    check("stop_keep_buf", 32'(s_ready), 0);
    en = 1'b1;
    wait_after(5);
    check("restart_cic", 32'(enb_cic), 1);
    wait_after(319);
    check("restart_in1", 32'(in1), 16'hABCD);
    check("restart_ready", 32'(s_ready), 1);

    // Saturating underrun count, then asynchronous reset mid-frame
    do_reset();
    out1 = 16'hFFFB;
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wait_after(319);
      check("sat_pulse", 32'(underrun), 1);
      check("sat_cnt", 32'(urun_cnt), (k < 7) ? k : 7);
    end
    s_valid = 1'b1; s_data = 16'h0101;
    @(negedge clk);
    s_valid = 1'b0;
    wait_after(170);
    check("pre_rst_in2", 32'(in2), 16'hFFFB);
    check("pre_rst_ready", 32'(s_ready), 0);
    rst_n = 1'b0;
    #1;
    check("arst_in2", 32'(in2), 0);
    check("arst_urun", 32'(urun_cnt), 0);
    check("arst_strobes", {enb_hbf1, enb_hbf2, enb_cic, underrun}, 0);
    check("arst_ready", 32'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
